// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Integer register file for the ID stage with a per-register busy
//   scoreboard. x0 is hardwired to zero; reads are registered (1 cycle)
//   and write-first, so a same-edge write is returned instead of stale data.
// Ports
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset (clears array, outputs, busy)
//   writereg  : WB write enable; rd / writedata give address and data
//   rs        : NREAD packed read addresses, port k = rs[k*AW +: AW]
//   readdata  : NREAD packed registered read data, port k = readdata[k*XLEN +: XLEN]
//   busy_set  : ID marks busy_rd as pending (awaiting a write)
//   rs_busy   : registered post-update busy flag of each read port's register
module regfile_scoreboard #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  writereg,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       writedata,
  input  logic [NREAD*AW-1:0]   rs,
  output logic [NREAD*XLEN-1:0] readdata,
  input  logic                  busy_set,
  input  logic [AW-1:0]         busy_rd,
  output logic [NREAD-1:0]      rs_busy
);

  logic [XLEN-1:0]       mem_q     [NREGS];
  logic [XLEN-1:0]       mem_d     [NREGS];
  logic [NREGS-1:0]      busy_q,     busy_d;
  logic [NREAD*XLEN-1:0] readdata_q, readdata_d;
  logic [NREAD-1:0]      rs_busy_q,  rs_busy_d;

  logic write_en;
  logic set_en;

  assign write_en = writereg && (rd != '0);
  assign set_en   = busy_set && (busy_rd != '0);

  always_comb begin
    mem_d = mem_q;
    if (write_en) begin
      mem_d[rd] = writedata;
    end

    // Clear first, then set: a new producer issued on the same edge as the
    // old producer's writeback keeps the register pending.
    busy_d = busy_q;
    if (write_en) begin
      busy_d[rd] = 1'b0;
    end
    if (set_en) begin
      busy_d[busy_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    // Reading from the next-state array and scoreboard gives write-first
    // data and the post-update busy flag in one lookup.
    readdata_d = '0;
    rs_busy_d  = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      if (rs[k*AW +: AW] != '0) begin
        readdata_d[k*XLEN +: XLEN] = mem_d[rs[k*AW +: AW]];
      end
      rs_busy_d[k] = busy_d[rs[k*AW +: AW]];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
      busy_q     <= '0;
      readdata_q <= '0;
      rs_busy_q  <= '0;
    end else begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      mem_q[0]   <= '0;
      busy_q     <= busy_d;
      readdata_q <= readdata_d;
      rs_busy_q  <= rs_busy_d;
    end
  end

  assign readdata = readdata_q;
  assign rs_busy  = rs_busy_q;

endmodule
